uart_rx_framer: RTL

- Receive front end for one UART channel of the multi-channel device array.
- Synchronises the raw rx pin, deserialises 8N1 bytes at a parameterised bit period, and delimits frames by line-idle timeout.
- Matches the first byte of each frame against the channel address.
- Feeds bytes plus frame/address flags downstream to the device's command logic. No backpressure: every byte is presented exactly once.

---
 rtl/uart_rx_framer.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: 8N1 UART receiver that delimits frames by line-idle timeout and matches the frame's first byte to UART_ADDR.
// Define UART_RX_PARITY_EN to require an even parity bit between the data and stop bits.
module uart_rx_framer #(
  parameter int UART_ADDR = 1,
  parameter int BCYC = 5208,
  parameter int TOCNTSIZE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       addr_match,
  output logic       frame_end,
  output logic       frame_err
);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAITHI} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;
`endif
  localparam logic [15:0] BC = 16'(BCYC);
  localparam logic [15:0] HALF = 16'(BCYC / 2);
  localparam logic [7:0] ADDR8 = 8'(UART_ADDR);
  state_t state, state_n;
  logic s1, s2, s3;
  logic [15:0] cnt;
  logic [2:0] bidx;
  logic [7:0] shreg;
  logic in_frame;
  logic [TOCNTSIZE-1:0] tocnt;
  logic line, fall, chg, tick, good, bad, par_ok, wrap;
  assign line = s2;
  assign fall = s3 & ~s2;
  assign chg = s3 ^ s2;
  assign tick = cnt == 16'd1;
  assign wrap = (state == IDLE) && in_frame && (&tocnt);
`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_ok = ~^{shreg, par_bit};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par_bit <= 1'b0;
    else if (state == PARITY && tick) par_bit <= line;
`else
  assign par_ok = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    good = 1'b0;
    bad = 1'b0;
    case (state)
      IDLE:   state_n = fall ? START : IDLE;
      START:  if (tick) state_n = line ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (tick && bidx == 3'd7) state_n = PARITY;
      PARITY: if (tick) state_n = STOP;
`else
      DATA:   if (tick && bidx == 3'd7) state_n = STOP;
`endif
      STOP: if (tick) begin
        state_n = line ? IDLE : WAITHI;
        good = line & par_ok;
        bad = ~(line & par_ok);
      end
      WAITHI: state_n = line ? IDLE : WAITHI;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {s1, s2, s3} <= 3'b111;
      cnt <= '0;
      bidx <= '0;
      shreg <= '0;
      in_frame <= 1'b0;
      tocnt <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_first <= 1'b0;
      addr_match <= 1'b0;
      frame_end <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      {s1, s2, s3} <= {rx, s1, s2};
      rx_valid <= good;
      rx_first <= good & ~in_frame;
      frame_err <= bad;
      frame_end <= wrap;
      if (state == IDLE) cnt <= HALF;
      else if (state != WAITHI) cnt <= tick ? BC : cnt - 16'd1;
      if (state == START) bidx <= '0;
      if (state == DATA && tick) begin
        shreg <= {line, shreg[7:1]};
        bidx <= bidx + 3'd1;
      end
      tocnt <= (state != IDLE || chg || !in_frame) ? '0 : tocnt + TOCNTSIZE'(1);
      if (good) begin
        rx_data <= shreg;
        in_frame <= 1'b1;
        if (!in_frame) addr_match <= shreg == ADDR8;
      end
      // a start edge coinciding with the wrap still closes the old frame
      if (wrap) begin
        in_frame <= 1'b0;
        addr_match <= 1'b0;
      end
    end
endmodule
